// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan sequencer: frame states,
// prefix byte values, the queued key event and the parity helper.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;
    localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;

    typedef struct packed {
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } ps2_event_t;

    // PS/2 uses odd parity over the eight data bits plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_scan_sequencer_if.sv
// Key-event valid/ready channel between the scan sequencer and its consumer.
interface ps2_scan_sequencer_if;

    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_break;
    logic       ev_ext;

    modport master (
        output ev_valid,
        output ev_code,
        output ev_break,
        output ev_ext,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_code,
        input  ev_break,
        input  ev_ext,
        output ev_ready
    );

endinterface

// File: rtl/ps2_event_fifo.sv
// Synchronous FIFO of key events; a push into a full FIFO is only taken when
// a pop happens in the same cycle, otherwise the entry is left untouched.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  ps2_event_t data_i,
    output logic       full_o,
    input  logic       pop_i,
    output logic       empty_o,
    output ps2_event_t head_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    ps2_event_t           mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 wr_en_s;
    logic                 rd_en_s;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == {CNT_W{1'b0}});
    assign head_o  = mem_q[rd_ptr_q];

    // Next-state for pointers and occupancy count.
    always_comb begin
        wr_en_s  = push_i && (!full_o || pop_i);
        rd_en_s  = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_en_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (wr_en_s && !rd_en_s) begin
            count_d = count_q + CNT_W'(1);
        end else if (rd_en_s && !wr_en_s) begin
            count_d = count_q - CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; cleared on reset so an empty FIFO presents an all-zero head.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

endmodule

// File: rtl/ps2_scan_sequencer.sv
// PS/2 keyboard receiver in the system clock domain: pin synchronizer, frame
// FSM with timeout, E0/F0 prefix folding and an event FIFO toward the core.
module ps2_scan_sequencer
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ps2_clk,
    input  logic                        ps2_data,
    ps2_scan_sequencer_if.master        ev,
    output logic                        frame_err,
    output logic                        overflow
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic             clk_meta_q, clk_sync_q, clk_prev_q;
    logic             data_meta_q, data_sync_q;
    logic             fall_s;
    logic             bit_s;

    ps2_state_t       state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             timeout_s;
    logic             byte_done_s;
    logic             bad_frame_s;

    logic             ext_pend_q, ext_pend_d;
    logic             brk_pend_q, brk_pend_d;
    logic             push_s;
    ps2_event_t       push_ev_s;
    logic             pop_s;
    logic             full_s;
    logic             empty_s;
    ps2_event_t       head_s;

    logic             frame_err_q, frame_err_d;
    logic             overflow_q, overflow_d;

    // Two-flop synchronizers plus the previous-clock register for edge detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= ps2_clk;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            data_meta_q <= ps2_data;
            data_sync_q <= data_meta_q;
        end
    end

    assign fall_s = clk_prev_q && !clk_sync_q;
    assign bit_s  = data_sync_q;

    // Frame FSM and timeout counter next-state; a timeout wins over an edge.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        tmo_d       = tmo_q;
        byte_done_s = 1'b0;
        bad_frame_s = 1'b0;
        timeout_s   = (state_q != IDLE) && (tmo_q == TMO_W'(TIMEOUT_CYCLES));

        if (timeout_s || fall_s || (state_q == IDLE)) begin
            tmo_d = {TMO_W{1'b0}};
        end else begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        if (timeout_s) begin
            state_d     = IDLE;
            bad_frame_s = 1'b1;
        end else if (fall_s) begin
            case (state_q)
                IDLE: begin
                    if (!bit_s) begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        state_d   = IDLE;
                    end
                end
                DATA: begin
                    shift_d   = {bit_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end else begin
                        state_d = DATA;
                    end
                end
                PARITY: begin
                    par_d   = bit_s;
                    state_d = STOP;
                end
                STOP: begin
                    if (bit_s && odd_parity_ok(shift_q, par_q)) begin
                        byte_done_s = 1'b1;
                    end else begin
                        bad_frame_s = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Frame FSM state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            par_q     <= 1'b0;
            tmo_q     <= {TMO_W{1'b0}};
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tmo_q     <= tmo_d;
        end
    end

    assign pop_s     = ev.ev_valid && ev.ev_ready;
    assign push_ev_s = '{code: shift_q, brk: brk_pend_q, ext: ext_pend_q};

    // Prefix folding: prefixes only set flags, any other byte becomes an event.
    always_comb begin
        ext_pend_d  = ext_pend_q;
        brk_pend_d  = brk_pend_q;
        push_s      = 1'b0;
        if (bad_frame_s) begin
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
        end else if (byte_done_s) begin
            if (shift_q == PS2_EXT_PREFIX) begin
                ext_pend_d = 1'b1;
            end else if (shift_q == PS2_BREAK_PREFIX) begin
                brk_pend_d = 1'b1;
            end else begin
                push_s     = 1'b1;
                ext_pend_d = 1'b0;
                brk_pend_d = 1'b0;
            end
        end else begin
            ext_pend_d = ext_pend_q;
            brk_pend_d = brk_pend_q;
        end
        frame_err_d = bad_frame_s;
        overflow_d  = push_s && full_s && !pop_s;
    end

    // Prefix flags and the registered status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            ext_pend_q  <= ext_pend_d;
            brk_pend_q  <= brk_pend_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_s),
        .data_i  (push_ev_s),
        .full_o  (full_s),
        .pop_i   (pop_s),
        .empty_o (empty_s),
        .head_o  (head_s)
    );

    assign ev.ev_valid = !empty_s;
    assign ev.ev_code  = head_s.code;
    assign ev.ev_break = head_s.brk;
    assign ev.ev_ext   = head_s.ext;
    assign frame_err   = frame_err_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// Directed and randomized checks of the PS/2 scan sequencer against a
// byte-level reference model of prefix folding and event queueing.
module tb_ps2_scan_sequencer;

    localparam int FIFO_DEPTH = 4;
    localparam int TMO        = 300;
    localparam int H          = 10;

    logic clk = 1'b0;
    logic rst;
    logic ps2_clk;
    logic ps2_data;
    logic frame_err;
    logic overflow;

    ps2_scan_sequencer_if ev_if ();

    ps2_scan_sequencer #(
        .FIFO_DEPTH     (FIFO_DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .ev        (ev_if),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    int ovf_seen = 0;
    int exp_err = 0;
    int exp_ovf = 0;

    logic [9:0] exp_q [$];
    bit m_brk = 1'b0;
    bit m_ext = 1'b0;

    logic s_v2, s_v3, s_err3, s_err4, s_ovf3, s_ovf4;

    always @(negedge clk) begin
        if (frame_err) err_seen++;
        if (overflow)  ovf_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: what one received byte does to the event stream.
    task automatic model_byte(input logic [7:0] b, input bit ok);
        if (!ok) begin
            exp_err++;
            m_brk = 1'b0;
            m_ext = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (exp_q.size() < FIFO_DEPTH) exp_q.push_back({b, m_brk, m_ext});
            else exp_ovf++;
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit badpar, input bit badstop, input bit popq);
        logic [10:0] bits;
        bits = {~badstop, (~^b) ^ badpar, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            ps2_data = bits[i];
            repeat (H) @(negedge clk);
            ps2_clk = 1'b0;
            if (i < 10) begin
                repeat (H) @(negedge clk);
                ps2_clk = 1'b1;
            end
        end
        @(posedge clk); @(posedge clk); #1;
        s_v2 = ev_if.ev_valid;
        ev_if.ev_ready = popq;
        @(posedge clk); #1;
        s_v3 = ev_if.ev_valid; s_err3 = frame_err; s_ovf3 = overflow;
        ev_if.ev_ready = 1'b0;
        @(posedge clk); #1;
        s_err4 = frame_err; s_ovf4 = overflow;
        repeat (H - 4) @(negedge clk);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (H) @(negedge clk);
    endtask

    task automatic send_partial(input logic [7:0] b, input int n);
        logic [10:0] bits;
        bits = {1'b1, ~^b, b, 1'b0};
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            repeat (H) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (H) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic key(input logic [7:0] b, input bit badpar, input bit badstop, input bit popq);
        logic [9:0] dropped;
        send_frame(b, badpar, badstop, popq);
        if (popq && exp_q.size() > 0) dropped = exp_q.pop_front();
        model_byte(b, !(badpar || badstop));
    endtask

    // Pops everything the DUT holds, comparing each head against the model.
    task automatic drain(input string tag);
        int n;
        int n0;
        logic [9:0] e;
        n  = 0;
        n0 = exp_q.size();
        for (int c = 0; c < FIFO_DEPTH + 4; c++) begin
            @(negedge clk);
            if (!ev_if.ev_valid) break;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3FF;
            chk({tag, "_head"}, {22'd0, ev_if.ev_code, ev_if.ev_break, ev_if.ev_ext}, {22'd0, e});
            n++;
            ev_if.ev_ready = 1'b1;
        end
        ev_if.ev_ready = 1'b0;
        chk({tag, "_count"}, n, n0);
        chk({tag, "_left"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        logic [7:0] code;
        int pre;
        bit bad;

        rst = 1'b1;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        ev_if.ev_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", {31'd0, ev_if.ev_valid}, 32'd0);
        chk("rst_code",  {24'd0, ev_if.ev_code}, 32'd0);
        chk("rst_flags", {30'd0, ev_if.ev_break, ev_if.ev_ext}, 32'd0);
        chk("rst_pulses", {30'd0, frame_err, overflow}, 32'd0);

        key(8'h1C, 1'b0, 1'b0, 1'b0);
        chk("lat_before", {31'd0, s_v2}, 32'd0);
        chk("lat_valid",  {31'd0, s_v3}, 32'd1);
        drain("plain_1c");

        key(8'hF0, 1'b0, 1'b0, 1'b0);
        chk("prefix_only", {31'd0, s_v3}, 32'd0);
        key(8'h1C, 1'b0, 1'b0, 1'b0);
        drain("break_1c");

        key(8'hE0, 1'b0, 1'b0, 1'b0);
        key(8'hF0, 1'b0, 1'b0, 1'b0);
        key(8'h75, 1'b0, 1'b0, 1'b0);
        drain("ext_brk_75");

        key(8'h1C, 1'b1, 1'b0, 1'b0);
        chk("par_err_t1", {31'd0, s_err3}, 32'd1);
        chk("par_err_t2", {31'd0, s_err4}, 32'd0);
        chk("par_no_ev",  {31'd0, s_v3}, 32'd0);
        key(8'hF0, 1'b0, 1'b0, 1'b0);
        key(8'h33, 1'b0, 1'b1, 1'b0);
        chk("stop_err", {31'd0, s_err3}, 32'd1);
        key(8'h1C, 1'b0, 1'b0, 1'b0);
        drain("after_bad_stop");
        chk("err_count1", err_seen, exp_err);

        key(8'hF0, 1'b0, 1'b0, 1'b0);
        send_partial(8'h55, 5);
        repeat (TMO + 40) @(negedge clk);
        exp_err++;
        m_brk = 1'b0;
        m_ext = 1'b0;
        chk("timeout_err", err_seen, exp_err);
        key(8'h2A, 1'b0, 1'b0, 1'b0);
        drain("after_timeout");

        key(8'h15, 1'b0, 1'b0, 1'b0);
        key(8'h1D, 1'b0, 1'b0, 1'b0);
        key(8'h24, 1'b0, 1'b0, 1'b0);
        key(8'h2D, 1'b0, 1'b0, 1'b0);
        chk("full_no_ovf", ovf_seen, 32'd0);
        key(8'h2C, 1'b0, 1'b0, 1'b0);
        chk("ovf_t1", {31'd0, s_ovf3}, 32'd1);
        chk("ovf_t2", {31'd0, s_ovf4}, 32'd0);
        chk("ovf_count", ovf_seen, exp_ovf);
        drain("full_drain");

        key(8'h16, 1'b0, 1'b0, 1'b0);
        key(8'h1E, 1'b0, 1'b0, 1'b0);
        key(8'h26, 1'b0, 1'b0, 1'b0);
        key(8'h25, 1'b0, 1'b0, 1'b0);
        key(8'h2E, 1'b0, 1'b0, 1'b1);
        chk("pushpop_no_ovf", {31'd0, s_ovf3}, 32'd0);
        chk("pushpop_ovf_count", ovf_seen, exp_ovf);
        drain("pushpop_drain");

        key(8'h11, 1'b0, 1'b0, 1'b0);
        key(8'h22, 1'b0, 1'b0, 1'b0);
        send_partial(8'h44, 5);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid", {31'd0, ev_if.ev_valid}, 32'd0);
        rst = 1'b0;
        exp_q.delete();
        m_brk = 1'b0;
        m_ext = 1'b0;
        key(8'h16, 1'b0, 1'b0, 1'b0);
        drain("after_rst");

        for (int k = 0; k < 10; k++) begin
            code = 8'($urandom_range(8'h01, 8'h7F));
            pre  = int'($urandom_range(0, 3));
            bad  = ($urandom_range(0, 5) == 0);
            if (pre >= 2) key(8'hE0, 1'b0, 1'b0, 1'b0);
            if (pre[0])   key(8'hF0, 1'b0, 1'b0, 1'b0);
            key(code, bad, 1'b0, 1'b0);
            drain("rand");
        end
        chk("final_err_count", err_seen, exp_err);
        chk("final_ovf_count", ovf_seen, exp_ovf);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
